// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle slave memory with a fixed number of wait states and byte-lane writes.
// Define WB_SLAVE_MEM_ERR_EN to terminate out-of-window accesses with wb_err_o instead of aliasing.
module wb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = {ADDR_WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  state_t                state_r, state_s;
  logic [3:0]            cnt_r, cnt_s;
  logic [DEPTH_LOG2-1:0] idx_r;
  logic [DATA_WIDTH-1:0] dat_r;
  logic [BYTES-1:0]      sel_r;
  logic                  we_r, oob_r;
  logic                  ack_r, err_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [ADDR_WIDTH-1:0] off_s;
  logic [DEPTH_LOG2-1:0] idx_in_s, idx_now_s;
  logic                  oob_in_s, oob_now_s, we_now_s, accept_s;
  logic                  unused_s;

  assign off_s    = wb_adr_i - BASE_ADDR;
  assign idx_in_s = off_s[OFF_BITS +: DEPTH_LOG2];
  assign unused_s = ^{1'b0, off_s};

`ifdef WB_SLAVE_MEM_ERR_EN
  localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] LIMIT    =
    BASE_EXT + ({{ADDR_WIDTH{1'b0}}, 1'b1} << (DEPTH_LOG2 + OFF_BITS));
  assign oob_in_s = ({1'b0, wb_adr_i} < BASE_EXT) || ({1'b0, wb_adr_i} >= LIMIT);
`else
  assign oob_in_s = 1'b0;
`endif

  // With zero wait states RESP is entered straight from IDLE, so attributes come from the bus.
  assign accept_s  = (state_r == IDLE) && wb_cyc_i && wb_stb_i;
  assign idx_now_s = (state_r == IDLE) ? idx_in_s : idx_r;
  assign we_now_s  = (state_r == IDLE) ? wb_we_i  : we_r;
  assign oob_now_s = (state_r == IDLE) ? oob_in_s : oob_r;

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (WAIT_STATES > 0) begin
            state_s = WAIT;
            cnt_s   = WS_LOAD;
          end else begin
            state_s = RESP;
            cnt_s   = 4'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!(wb_cyc_i && wb_stb_i)) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_s = RESP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, captured request and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= {DATA_WIDTH{1'b0}};
      idx_r   <= {DEPTH_LOG2{1'b0}};
      dat_r   <= {DATA_WIDTH{1'b0}};
      sel_r   <= {BYTES{1'b0}};
      we_r    <= 1'b0;
      oob_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_r   <= (state_s == RESP) && !oob_now_s;
      err_r   <= (state_s == RESP) && oob_now_s;
      rdata_r <= ((state_s == RESP) && !we_now_s && !oob_now_s) ? mem_r[idx_now_s]
                                                              : {DATA_WIDTH{1'b0}};
      if (accept_s) begin
        idx_r <= idx_in_s;
        dat_r <= wb_dat_i;
        sel_r <= wb_sel_i;
        we_r  <= wb_we_i;
        oob_r <= oob_in_s;
      end
    end
  end

  // Byte-lane write commit at the end of the RESP cycle; a reset in that cycle drops it.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == RESP) && we_r && !oob_r) begin
      for (int b = 0; b < BYTES; b++) begin
        if (sel_r[b]) begin
          mem_r[idx_r][b*8 +: 8] <= dat_r[b*8 +: 8];
        end
      end
    end
  end

  assign wb_ack_o = ack_r;
  assign wb_err_o = err_r;
  assign wb_dat_o = rdata_r;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed self-checking bench for wb_slave_mem (32-bit data, 2 wait states, base 0).
// Expectations follow WB_SLAVE_MEM_ERR_EN when it is defined for the build.
module tb_wb_slave_mem;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr = 32'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [3:0]  wb_sel = 4'd0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic        wb_err;

  int n_checks = 0;
  int n_fail   = 0;

  wb_slave_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(WS), .BASE_ADDR(32'd0)
  ) dut (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel),
    .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One classic cycle; returns the response seen and the cycle count from drive to response.
  task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, output logic [31:0] rdata, output logic ackd,
                         output logic errd, output int lat);
    lat = 0; ackd = 1'b0; errd = 1'b0; rdata = 32'd0;
    @(negedge clk);
    wb_adr = adr; wb_dat_i = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (wb_ack || wb_err) begin
        lat = k; ackd = wb_ack; errd = wb_err; rdata = wb_dat_o;
        break;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    check("pulse_width", {62'd0, wb_ack, wb_err}, 64'd0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    logic [31:0] rd; logic ak, er; int lat;
    wb_xfer(adr, dat, sel, 1'b1, rd, ak, er, lat);
    check({tag, "_ack"}, {62'd0, ak, er}, 64'd2);
    check({tag, "_lat"}, 64'(lat), 64'(WS + 1));
  endtask

  task automatic do_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd; logic ak, er; int lat;
    wb_xfer(adr, 32'd0, 4'hF, 1'b0, rd, ak, er, lat);
    check({tag, "_ack"}, {62'd0, ak, er}, 64'd2);
    check({tag, "_lat"}, 64'(lat), 64'(WS + 1));
    check({tag, "_data"}, {32'd0, rd}, {32'd0, exp});
  endtask

  initial begin
    logic [31:0] rd; logic ak, er; int lat; int acks; logic seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ack", {63'd0, wb_ack}, 64'd0);
      check("idle_err", {63'd0, wb_err}, 64'd0);
      check("idle_dat", {32'd0, wb_dat_o}, 64'd0);
    end

    do_write("wr10", 32'h10, 32'hDEADBEEF, 4'hF);
    do_read("rd10", 32'h10, 32'hDEADBEEF);
    do_read("rd13_offset", 32'h13, 32'hDEADBEEF);

    do_write("wr20_full", 32'h20, 32'h11223344, 4'hF);
    do_write("wr20_lanes", 32'h20, 32'hAABBCCDD, 4'h5);
    do_read("rd20_lanes", 32'h20, 32'h11BB33DD);
    do_write("wr20_sel0", 32'h20, 32'hFFFFFFFF, 4'h0);
    do_read("rd20_sel0", 32'h20, 32'h11BB33DD);

    // Abort: drop stb after one wait cycle.
    do_write("wr30_prior", 32'h30, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    wb_adr = 32'h30; wb_dat_i = 32'h55; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(negedge clk);
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wb_ack || wb_err) acks++;
    end
    check("abort_no_ack", 64'(acks), 64'd0);
    do_read("rd30_abort", 32'h30, 32'h0BADF00D);

    // Reset asserted during the RESP cycle of a write.
    do_write("wr40_prior", 32'h40, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    wb_adr = 32'h40; wb_dat_i = 32'h12345678; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (wb_ack) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_resp_seen", {63'd0, seen}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ack", {62'd0, wb_ack, wb_err}, 64'd0);
    check("rst_dat", {32'd0, wb_dat_o}, 64'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; rst = 1'b0;
    do_read("rd40_rst", 32'h40, 32'hCAFEF00D);

    // Out-of-window write at 0x1000.
    do_write("wr0_prior", 32'h0, 32'hA5A5A5A5, 4'hF);
    wb_xfer(32'h1000, 32'h5A5A5A5A, 4'hF, 1'b1, rd, ak, er, lat);
    check("oob_lat", 64'(lat), 64'(WS + 1));
`ifdef WB_SLAVE_MEM_ERR_EN
    check("oob_resp", {62'd0, ak, er}, 64'd1);
    check("oob_dat", {32'd0, rd}, 64'd0);
    do_read("rd0_oob", 32'h0, 32'hA5A5A5A5);
`else
    check("oob_resp", {62'd0, ak, er}, 64'd2);
    do_read("rd0_alias", 32'h0, 32'h5A5A5A5A);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
